// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FQ_IDLE    = 2'd0,
    FQ_REQ     = 2'd1,
    FQ_DISCARD = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs; head is zeroed when empty.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_inst,
  output logic [AW:0]   o_count,
  output logic          o_valid,
  output logic [31:0]   o_head_pc,
  output logic [31:0]   o_head_inst
);

  fq_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  fq_entry_t       w_head;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear && !rst) begin
      r_mem[r_wptr] <= '{pc: i_pc, inst: i_inst};
    end
  end

  always_comb begin
    w_head      = r_mem[r_rptr];
    o_count     = r_count;
    o_valid     = (r_count != '0);
    o_head_pc   = o_valid ? w_head.pc   : ZERO_WORD;
    o_head_inst = o_valid ? w_head.inst : ZERO_WORD;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: req/ack handshake to instruction memory feeding a DEPTH-entry queue.
// Optional FETCH_STAT_EN adds wait_cycles_o, a saturating memory-wait counter.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush,
  input  logic        id_stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        stallreq_o,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] wait_cycles_o
`endif
);

  localparam int unsigned OW = AW + 2;

  fq_state_e   r_state;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;

  logic        w_push;
  logic        w_pop;
  logic        w_accept;
  logic [AW:0] w_count;
  logic [OW-1:0] w_occ;

  // Occupancy projects this cycle's push/pop so a full queue can still accept
  // when the head drains in the same cycle.
  always_comb begin
    w_push     = (r_state == FQ_REQ) & mem_ack_i & ~flush;
    w_pop      = id_valid_o & ~id_stall_i & ~flush;
    w_occ      = OW'(w_count) + OW'(w_push) - OW'(w_pop);
    w_accept   = ce_i & ~flush & (w_occ < OW'(DEPTH))
               & ((r_state == FQ_IDLE) | w_push);
    stallreq_o = ce_i & ~w_accept;
    mem_req_o  = r_mem_req;
    mem_addr_o = r_mem_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FQ_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= ZERO_WORD;
    end else if (flush) begin
      // An unacked request must still complete on the bus; its data is dropped.
      unique case (r_state)
        FQ_REQ, FQ_DISCARD: begin
          if (mem_ack_i) begin
            r_state   <= FQ_IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_state   <= FQ_DISCARD;
          end
        end
        default: r_state <= FQ_IDLE;
      endcase
    end else if (w_accept) begin
      r_state    <= FQ_REQ;
      r_mem_req  <= 1'b1;
      r_mem_addr <= pc_i;
    end else begin
      unique case (r_state)
        FQ_REQ, FQ_DISCARD: begin
          if (mem_ack_i) begin
            r_state   <= FQ_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: r_state <= FQ_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (flush),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_pc        (r_mem_addr),
    .i_inst      (mem_data_i),
    .o_count     (w_count),
    .o_valid     (id_valid_o),
    .o_head_pc   (id_pc_o),
    .o_head_inst (id_inst_o)
  );

`ifdef FETCH_STAT_EN
  logic [31:0] r_wait_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cycles <= '0;
    end else if ((r_state == FQ_REQ || r_state == FQ_DISCARD) && !mem_ack_i
                 && r_wait_cycles != '1) begin
      r_wait_cycles <= r_wait_cycles + 32'd1;
    end
  end

  assign wait_cycles_o = r_wait_cycles;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: vector table for reset/streaming, scoreboard of accepted PCs.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush;
  logic        id_stall_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        stallreq_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
`ifdef FETCH_STAT_EN
  logic [31:0] wait_cycles_o;
`endif

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH (4),
    .AW    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .flush      (flush),
    .id_stall_i (id_stall_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .stallreq_o (stallreq_o),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
`ifdef FETCH_STAT_EN
    ,
    .wait_cycles_o (wait_cycles_o)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: acks once the request has been held ack_delay cycles.
  logic        model_on = 1'b0;
  logic        tb_ack   = 1'b0;
  int unsigned ack_delay = 0;
  int unsigned req_age   = 0;

  assign mem_ack_i  = model_on ? (mem_req_o && (req_age >= ack_delay)) : tb_ack;
  assign mem_data_i = memf(mem_addr_o);

  always @(posedge clk) begin
    if (mem_req_o && !mem_ack_i) req_age <= req_age + 1;
    else                         req_age <= 0;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted PCs queue up; every pop must match the oldest one.
  task automatic sb();
    logic [31:0] p;
    if (!rst) begin
      if (id_valid_o && !id_stall_i && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", id_pc_o, $time);
        end else begin
          p = exp_q.pop_front();
          chk("pop_pc", id_pc_o, p);
          chk("pop_inst", id_inst_o, memf(p));
        end
      end
      if (!id_valid_o) begin
        chk("empty_pc", id_pc_o, 32'h0);
        chk("empty_inst", id_inst_o, 32'h0);
      end
      if (ce_i && !stallreq_o) exp_q.push_back(pc_i);
      if (flush) exp_q.delete();
    end
  endtask

  task automatic tick();
    sb();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ce, input logic [31:0] pc, input logic st, input logic fl);
    ce_i = ce;
    pc_i = pc;
    id_stall_i = st;
    flush = fl;
    #1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    ack_delay = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      if (exp_q.size() == 0 && !id_valid_o && !mem_req_o) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_done", done, 1'b1);
  endtask

  typedef struct {
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        ack;
    logic        chk;
    logic        exp_stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc_cur;
    logic        acc;
    int          n_addr, n_stall, n_disc;
    logic        got;
`ifdef FETCH_STAT_EN
    logic [31:0] w0;
`endif

    //           rst   ce    pc     ack   chk   stall req   addr   valid id_pc
    vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4};
    vecs[6] = '{1'b0, 1'b0, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 32'h8};
    vecs[7] = '{1'b0, 1'b0, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b0, 32'h0};

    rst = 1'b1; ce_i = 1'b1; pc_i = '0; flush = 1'b0; id_stall_i = 1'b0;
    @(negedge clk);

    // Reset and zero-wait streaming
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      tb_ack = vecs[i].ack;
      drive(vecs[i].ce, vecs[i].pc, 1'b0, 1'b0);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_stallreq", i), stallreq_o, vecs[i].exp_stall);
        chk($sformatf("v%0d_mem_req", i), mem_req_o, vecs[i].exp_req);
        chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].exp_addr);
        chk($sformatf("v%0d_id_valid", i), id_valid_o, vecs[i].exp_valid);
        chk($sformatf("v%0d_id_pc", i), id_pc_o, vecs[i].exp_pc);
        chk($sformatf("v%0d_id_inst", i), id_inst_o,
            vecs[i].exp_valid ? memf(vecs[i].exp_pc) : 32'h0);
      end
      tick();
    end
    tb_ack = 1'b0;
    model_on = 1'b1;
    drain();

    // Full queue under decode stall, then release
    ack_delay = 0;
    pc_cur = 32'h0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pc_cur, 1'b1, 1'b0);
      acc = !stallreq_o;
      tick();
      if (acc) pc_cur = pc_cur + 32'd4;
    end
    drive(1'b1, pc_cur, 1'b1, 1'b0);
    chk("full_pc_hold", pc_cur, 32'h10);
    chk("full_stallreq", stallreq_o, 1'b1);
    chk("full_valid", id_valid_o, 1'b1);
    tick();
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    chk("release_accept", stallreq_o, 1'b0);
    chk("release_pop_pc", id_pc_o, 32'h0);
    tick();
    drain();

    // Three-cycle memory wait
    ack_delay = 3;
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    chk("wait_accept", stallreq_o, 1'b0);
`ifdef FETCH_STAT_EN
    w0 = wait_cycles_o;
`endif
    tick();
    n_addr = 0; n_stall = 0; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h24, 1'b0, 1'b0);
      if (mem_req_o && mem_addr_o == 32'h20) n_addr++;
      if (stallreq_o) n_stall++;
      if (mem_ack_i) begin
        got = 1'b1;
`ifdef FETCH_STAT_EN
        chk("wait_cycles_delta", wait_cycles_o - w0, 32'd3);
`endif
        tick();
        break;
      end
      tick();
    end
    chk("wait_ack_seen", got, 1'b1);
    chk("wait_addr_cycles", n_addr, 32'd4);
    chk("wait_stall_cycles", n_stall, 32'd3);
    drain();

    // Flush with two queued entries and a request outstanding
    ack_delay = 0;
    drive(1'b1, 32'h40, 1'b1, 1'b0); chk("f_acc0", stallreq_o, 1'b0); tick();
    drive(1'b1, 32'h44, 1'b1, 1'b0); chk("f_acc1", stallreq_o, 1'b0); tick();
    drive(1'b1, 32'h48, 1'b1, 1'b0); chk("f_acc2", stallreq_o, 1'b0); tick();
    ack_delay = 5;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("f_pre_req", mem_req_o, 1'b1);
    chk("f_pre_addr", mem_addr_o, 32'h48);
    chk("f_pre_head", id_pc_o, 32'h40);
    tick();
    drive(1'b1, 32'h80, 1'b1, 1'b1);
    chk("f_flush_stall", stallreq_o, 1'b1);
    tick();
    n_disc = 0; got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h80, 1'b0, 1'b0);
      if (i == 0) chk("f_valid_cleared", id_valid_o, 1'b0);
      if (!stallreq_o) begin
        got = 1'b1;
        chk("f_idle_after", mem_req_o, 1'b0);
        tick();
        break;
      end
      if (mem_req_o) n_disc++;
      if (id_valid_o) chk("f_no_discard_data", id_valid_o, 1'b0);
      tick();
    end
    chk("f_reaccept", got, 1'b1);
    chk("f_discard_cycles", n_disc, 32'd4);
    drain();

    // Flush coincident with ack
    ack_delay = 2;
    drive(1'b1, 32'hA0, 1'b0, 1'b0); chk("fa_acc", stallreq_o, 1'b0); tick();
    drive(1'b1, 32'hA4, 1'b0, 1'b0); chk("fa_wait0", stallreq_o, 1'b1); tick();
    drive(1'b1, 32'hA4, 1'b0, 1'b0); chk("fa_wait1", stallreq_o, 1'b1); tick();
    drive(1'b1, 32'hA4, 1'b0, 1'b1);
    chk("fa_ack", mem_ack_i, 1'b1);
    chk("fa_no_accept", stallreq_o, 1'b1);
    tick();
    drive(1'b1, 32'hA4, 1'b0, 1'b0);
    chk("fa_idle_req", mem_req_o, 1'b0);
    chk("fa_idle_accept", stallreq_o, 1'b0);
    chk("fa_no_push", id_valid_o, 1'b0);
    tick();
    drain();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
